// File: rtl/aes_stream_ctrl_if.sv
// rtl/aes_stream_ctrl_if.sv - block stream and aes_core/key ROM interfaces
interface aes_stream_ctrl_if #(
  parameter int BLK_W  = 128,
  parameter int ADDR_W = 5,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [BLK_W-1:0]  in_block;
  logic              in_encdec;
  logic              in_keylen;
  logic [ADDR_W-1:0] in_key_addr;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [BLK_W-1:0]  out_block;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  modport master (
    output in_valid, in_block, in_encdec, in_keylen, in_key_addr, in_tag, out_ready,
    input  in_ready, out_valid, out_block, out_tag, busy
  );
  modport slave (
    input  in_valid, in_block, in_encdec, in_keylen, in_key_addr, in_tag, out_ready,
    output in_ready, out_valid, out_block, out_tag, busy
  );
endinterface

interface aes_core_if #(
  parameter int BLK_W  = 128,
  parameter int ADDR_W = 5
);
  logic              reset_n;
  logic              init;
  logic              next;
  logic              encdec;
  logic              keylen;
  logic [255:0]      key;
  logic [BLK_W-1:0]  block;
  logic              ready;
  logic [BLK_W-1:0]  result;
  logic              result_valid;
  logic              en_key;
  logic [ADDR_W-1:0] rom_addr;
  logic [127:0]      rom_dout;

  modport ctrl (
    output reset_n, init, next, encdec, keylen, key, block, en_key, rom_addr,
    input  ready, result, result_valid, rom_dout
  );
  modport core (
    input  reset_n, init, next, encdec, keylen, key, block, en_key, rom_addr,
    output ready, result, result_valid, rom_dout
  );
endinterface

// File: rtl/aes_stream_ctrl.sv
// rtl/aes_stream_ctrl.sv - streaming AES controller with key cache and output FIFO
module aes_stream_ctrl #(
  parameter int BLK_W     = 128,
  parameter int ADDR_W    = 5,
  parameter int TAG_W     = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  aes_stream_ctrl_if.slave bus,
  aes_core_if.ctrl         core
);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    IDLE, KEY_RD0, KEY_RD1, KEY_INIT, KEY_WAIT, BLK_NEXT, BLK_WAIT
  } state_t;

  state_t            state, state_nxt;
  logic [BLK_W-1:0]  blk;
  logic              encdec, keylen;
  logic [ADDR_W-1:0] addr;
  logic [TAG_W-1:0]  tag;
  logic              key_valid;
  logic [ADDR_W-1:0] cached_addr;
  logic              cached_keylen;
  logic [255:0]      key;
  logic              pend_hi, pend_lo;
  logic              seen_busy;
  logic [BLK_W+TAG_W-1:0] mem [OUT_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              accept, hit, push, pop, en_key, init, next;
  logic [ADDR_W-1:0] rom_addr;

  assign bus.in_ready = !rst && state == IDLE && count < CW'(OUT_DEPTH);
  assign accept = bus.in_valid && bus.in_ready;
  assign hit    = key_valid && bus.in_key_addr == cached_addr && bus.in_keylen == cached_keylen;
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    state_nxt = state;
    en_key    = 1'b0;
    rom_addr  = addr;
    init      = 1'b0;
    next      = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE:     if (accept) state_nxt = hit ? BLK_NEXT : KEY_RD0;
      KEY_RD0: begin
        en_key    = 1'b1;
        state_nxt = keylen ? KEY_RD1 : KEY_INIT;
      end
      KEY_RD1: begin
        en_key    = 1'b1;
        rom_addr  = addr + ADDR_W'(1);
        state_nxt = KEY_INIT;
      end
      // ROM data lands one cycle after each read; hold init until both halves are in
      KEY_INIT: if (core.ready && !pend_hi && !pend_lo) begin
        init      = 1'b1;
        state_nxt = KEY_WAIT;
      end
      KEY_WAIT: if (seen_busy && core.ready) state_nxt = BLK_NEXT;
      BLK_NEXT: begin
        next      = 1'b1;
        state_nxt = BLK_WAIT;
      end
      BLK_WAIT: if (seen_busy && core.ready && core.result_valid) begin
        push      = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_valid <= 1'b0;
      seen_busy <= 1'b0;
      pend_hi   <= 1'b0;
      pend_lo   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state   <= state_nxt;
      pend_hi <= state == KEY_RD0;
      pend_lo <= state == KEY_RD1;
      if (pend_hi) key[255:128] <= core.rom_dout;
      if (pend_lo) key[127:0] <= core.rom_dout;
      if (state == KEY_RD0 && !keylen) key[127:0] <= '0;
      if (accept) begin
        blk    <= bus.in_block;
        encdec <= bus.in_encdec;
        keylen <= bus.in_keylen;
        addr   <= bus.in_key_addr;
        tag    <= bus.in_tag;
        if (!hit) key_valid <= 1'b0;
      end
      if (init || next) seen_busy <= 1'b0;
      else if ((state == KEY_WAIT || state == BLK_WAIT) && !core.ready) seen_busy <= 1'b1;
      if (state == KEY_WAIT && seen_busy && core.ready) begin
        key_valid     <= 1'b1;
        cached_addr   <= addr;
        cached_keylen <= keylen;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {core.result, tag};
  end

  assign {bus.out_block, bus.out_tag} = mem[rd_ptr];
  assign bus.out_valid = count != '0;
  assign bus.busy      = state != IDLE;

  assign core.reset_n  = ~rst;
  assign core.init     = init;
  assign core.next     = next;
  assign core.encdec   = encdec;
  assign core.keylen   = keylen;
  assign core.key      = key;
  assign core.block    = blk;
  assign core.en_key   = en_key;
  assign core.rom_addr = rom_addr;
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb/tb_aes_stream_ctrl.sv - directed bench for aes_stream_ctrl with core and key ROM models
module tb_aes_stream_ctrl;
  localparam int BLK_W = 128, ADDR_W = 5, TAG_W = 4, OUT_DEPTH = 4;
  localparam logic [127:0] K0    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1    = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_stream_ctrl_if #(.BLK_W(BLK_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus();
  aes_core_if #(.BLK_W(BLK_W), .ADDR_W(ADDR_W)) core();

  aes_stream_ctrl #(.BLK_W(BLK_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .core(core)
  );

  // known-answer stand-in for aes_core: only the FIPS-197 vectors are recognised
  function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic kl,
                                           input logic ed, input logic [127:0] b);
    logic [127:0] ct;
    if (!kl && k == {K0, 128'h0}) ct = CT128;
    else if (kl && k == {K0, K1}) ct = CT256;
    else return ~b;
    if (ed && b == PT) return ct;
    if (!ed && b == ct) return PT;
    return ~b;
  endfunction

  logic [127:0] rom [32];
  logic [255:0] exp_key;
  logic         exp_len, op_next, op_ed;
  logic [127:0] op_blk;
  int           cnt;

  always @(posedge clk) begin
    if (core.en_key) core.rom_dout <= rom[core.rom_addr];
    if (!core.reset_n) begin
      core.ready        <= 1'b1;
      core.result_valid <= 1'b0;
      cnt               <= 0;
      op_next           <= 1'b0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core.ready <= 1'b1;
        if (op_next) begin
          core.result       <= aes_ref(exp_key, exp_len, op_ed, op_blk);
          core.result_valid <= 1'b1;
        end
      end
    end else if (core.init) begin
      core.ready        <= 1'b0;
      core.result_valid <= 1'b0;
      cnt               <= 6;
      op_next           <= 1'b0;
      exp_key           <= core.key;
      exp_len           <= core.keylen;
    end else if (core.next) begin
      core.ready        <= 1'b0;
      core.result_valid <= 1'b0;
      cnt               <= 4;
      op_next           <= 1'b1;
      op_blk            <= core.block;
      op_ed             <= core.encdec;
    end
  end

  int n_init, n_next, n_en;
  logic [ADDR_W-1:0]      rd_addrs [$];
  logic [TAG_W+BLK_W-1:0] got_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (core.init) n_init++;
      if (core.next) n_next++;
      if (core.en_key) begin
        n_en++;
        rd_addrs.push_back(core.rom_addr);
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_tag, bus.out_block});
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [TAG_W+BLK_W-1:0] got(input int i);
    return (i < got_q.size()) ? got_q[i] : '1;
  endfunction

  function automatic int ra(input int i);
    return (i < rd_addrs.size()) ? int'(rd_addrs[i]) : -1;
  endfunction

  task automatic clr();
    got_q.delete();
    rd_addrs.delete();
    n_init = 0;
    n_next = 0;
    n_en   = 0;
  endtask

  task automatic send(input logic [127:0] b, input logic ed, input logic kl,
                      input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
    int n = 0;
    @(posedge clk);
    #1;
    bus.in_block    = b;
    bus.in_encdec   = ed;
    bus.in_keylen   = kl;
    bus.in_key_addr = a;
    bus.in_tag      = t;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (got_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("out_count", got_q.size(), n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] exp_blk;
    int k;
    for (int i = 0; i < 32; i++) rom[i] = '0;
    rom[0] = K0; rom[2] = K0; rom[3] = K1; rom[31] = K0;
    bus.in_valid = 1'b0; bus.in_block = '0; bus.in_encdec = 1'b0;
    bus.in_keylen = 1'b0; bus.in_key_addr = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    clr();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);

    clr();
    send(PT, 1'b1, 1'b0, 5'd0, 4'd3);
    wait_out(1);
    chk("enc128_block", got(0)[127:0], CT128);
    chk("enc128_tag", got(0)[131:128], 3);
    chk("enc128_init", n_init, 1);
    chk("enc128_rom_reads", n_en, 1);
    chk("enc128_rom_addr", ra(0), 0);

    clr();
    send(CT128, 1'b0, 1'b0, 5'd0, 4'd5);
    wait_out(1);
    chk("dec128_block", got(0)[127:0], PT);
    chk("dec128_tag", got(0)[131:128], 5);
    chk("dec128_no_init", n_init, 0);
    chk("dec128_no_rom", n_en, 0);

    clr();
    send(PT, 1'b1, 1'b1, 5'd2, 4'd7);
    wait_out(1);
    chk("enc256_block", got(0)[127:0], CT256);
    chk("enc256_tag", got(0)[131:128], 7);
    chk("enc256_rom_reads", n_en, 2);
    chk("enc256_rom_addr0", ra(0), 2);
    chk("enc256_rom_addr1", ra(1), 3);
    chk("enc256_init", n_init, 1);

    clr();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send((i % 2 == 0) ? PT : CT128, (i % 2 == 0), 1'b0, 5'd0, TAG_W'(i));
    k = 0;
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_head_block", bus.out_block, CT128);
    chk("full_head_tag", bus.out_tag, 0);
    repeat (3) @(negedge clk);
    chk("stall_block_stable", bus.out_block, CT128);
    chk("stall_tag_stable", bus.out_tag, 0);
    chk("stream_init", n_init, 1);
    chk("stream_rom_reads", n_en, 1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(PT, 1'b1, 1'b0, 5'd0, 4'd4);
    wait_out(5);
    for (int i = 0; i < 5; i++) begin
      exp_blk = (i % 2 == 0) ? CT128 : PT;
      chk($sformatf("stream_block%0d", i), got(i)[127:0], exp_blk);
      chk($sformatf("stream_tag%0d", i), got(i)[131:128], i);
    end
    repeat (10) @(negedge clk);
    chk("stream_no_dup", got_q.size(), 5);

    clr();
    send(PT, 1'b1, 1'b0, 5'd0, 4'd9);
    k = 0;
    while (n_next == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort_saw_next", n_next, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_output", got_q.size(), 0);
    clr();
    send(PT, 1'b1, 1'b0, 5'd0, 4'd10);
    wait_out(1);
    chk("reissue_block", got(0)[127:0], CT128);
    chk("reissue_tag", got(0)[131:128], 10);
    chk("reissue_init", n_init, 1);

    rom[0] = K1;
    clr();
    send(PT, 1'b1, 1'b1, 5'd31, 4'd11);
    wait_out(1);
    chk("wrap_block", got(0)[127:0], CT256);
    chk("wrap_rom_reads", n_en, 2);
    chk("wrap_rom_addr0", ra(0), 31);
    chk("wrap_rom_addr1", ra(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_stream_ctrl.md
Name: aes_stream_ctrl

Overview:
- Streaming, parametrised successor to the single-shot AES top level.
- Accepts plaintext or ciphertext blocks over a valid/ready handshake, with a per-block mode (encrypt/decrypt), key length (128/256) and key-ROM address.
- Caches the expanded key: the key ROM is re-read and aes_core re-initialised only when the key address or key length changes.
- Results go into an output FIFO with valid/ready backpressure and a per-block tag. Sits between the system bus adapter and aes_core/ROM_key.

Parameters:
- BLK_W, 128, block width; fixed by aes_core, must be 128.
- ADDR_W, 5, key ROM address width.
- TAG_W, 4, width of the user tag carried with each block.
- OUT_DEPTH, 4, output FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input block offered.
- in_ready  out  1  block accepted when in_valid&&in_ready at a clock edge.
- in_block  in  BLK_W  plaintext (encrypt) or ciphertext (decrypt).
- in_encdec  in  1  1=encrypt, 0=decrypt (aes_core encdec).
- in_keylen  in  1  0=128-bit key, 1=256-bit key.
- in_key_addr  in  ADDR_W  ROM address of key word 0; a 256-bit key also uses addr+1.
- in_tag  in  TAG_W  user tag, returned with the result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops the head on out_valid&&out_ready.
- out_block  out  BLK_W  result block.
- out_tag  out  TAG_W  tag of the result block.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, key_valid=0, FIFO empty, out_valid=0, busy=0, in_ready=0 while rst is high. aes_core reset_n=~rst. Reset mid-operation aborts the in-flight block; no output is produced for it.
- in_ready = !rst && state==IDLE && fifo_count<OUT_DEPTH. Only one block is in flight.
- Acceptance registers block, encdec, keylen, addr and tag.
  - If key_valid and addr==cached_addr and keylen==cached_keylen: go to BLK_NEXT (key hit).
  - Otherwise: go to KEY_RD0 (key miss).
- KEY_RD0: en_key=1, ROM addr=addr. Next cycle (1-cycle ROM latency) dout is latched as key[255:128]. Go to KEY_RD1 if keylen=1, else KEY_INIT with key[127:0]=0.
- KEY_RD1: ROM addr=addr+1, wrapping modulo 2^ADDR_W. dout is latched as key[127:0]. Go to KEY_INIT.
- KEY_INIT: wait until core ready=1, then pulse init for 1 cycle and clear seen_busy. Go to KEY_WAIT.
- KEY_WAIT: set seen_busy when core ready=0. When seen_busy && ready=1: set key_valid=1, update cached_addr and cached_keylen, go to BLK_NEXT.
- BLK_NEXT: pulse next for 1 cycle with block/encdec applied, clear seen_busy. Go to BLK_WAIT.
- BLK_WAIT: when seen_busy && ready && result_valid, push {result, tag} into the FIFO, then go to IDLE.
- The FIFO is never full at push time, guaranteed by the acceptance rule.
- A simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- out_block/out_tag are stable while out_valid && !out_ready.
- FIFO pointers wrap modulo OUT_DEPTH. The count width is clog2(OUT_DEPTH)+1.
- A decrypt after an encrypt with the same key is a key hit; aes_core holds both schedules.
- A change of in_encdec alone never triggers a re-read.
- Minimum latency from acceptance to out_valid:
  - Key hit: 3 cycles plus the aes_core round time.
  - Key miss: additionally the ROM read(s) plus key-expansion time.

Test Plan:
- Reset, then ROM[0]=000102…0f, encrypt 00112233445566778899aabbccddeeff, tag 3 -> out_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_tag=3, exactly one init pulse.
- Same key, decrypt 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff, no en_key and no init pulse (key hit).
- ROM[2]=000102…0f, ROM[3]=101112…1f, keylen=1, addr=2, encrypt 00112233…eeff -> 8ea2b7ca516745bfeafc49904b496089; two ROM reads at 2 then 3.
- Hold out_ready=0 and stream 5 blocks with OUT_DEPTH=4 -> in_ready stays 0 after the 4th result; release -> results in order with tags 0..4, no loss or duplication.
- Assert rst during BLK_WAIT, then reissue the FIPS vector -> no output for the aborted block; key miss on reissue (init pulse); correct result.
- addr=31 with keylen=1 -> second ROM read at address 0 (wrap).
